alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (e.g. datapath issue and debug/test port).
//  Arbitrates, registers operands, sequences a single ALU op, returns a registered result over a valid/ready response channel.
//  Sits between the requesters and the single instance of module ALU.
// PARAMETERS
//  WIDTH   32  operand/result width (BusA, BusB, BusW)
//  CTRL_W  4   ALUCtrl width
// PORTS
//  CLK          in   1       single clock, rising edge
//  ResetL       in   1       reset, asynchronous, active-low
//  ReqValid0/1  in   1       requester n presents an op
//  ReqReady0/1  out  1       1-cycle accept pulse to requester n
//  ReqA0/1      in   WIDTH   operand A
//  ReqB0/1      in   WIDTH   operand B (shift amount for SLL/SRL/SRA)
//  ReqCtrl0/1   in   CTRL_W  ALU op code
//  RespValid    out  1       result available
//  RespReady    in   1       consumer takes result
//  RespId       out  1       requester that issued the op (0/1)
//  RespData     out  WIDTH   ALU BusW, registered
//  RespZero     out  1       ALU Zero flag, registered
//  RespErr      out  1       op code undefined (5 or 15)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: all outputs 0; FSM=IDLE; LastGnt=1 (requester 0 wins first); operand regs 0.
//  FSM IDLE: if any ReqValid -> grant per arbitration; ReqReady<g>=1 that cycle; latch A/B/Ctrl/Id; -> EXEC.
//   No ReqValid -> stay IDLE.
//  EXEC: ALU fed from operand regs; latch BusW->RespData, Zero->RespZero, Err; -> RESP.
//  RESP: RespValid=1; RespId/Data/Zero/Err stable until RespValid&&RespReady; that cycle -> IDLE.
//  Latency: accept at cycle t -> RespValid at t+2; min issue interval 3 cycles (no overlap).
//  ReqReady never asserted outside IDLE; ReqValid ignored in EXEC/RESP.
//  Requester must hold ReqValid/operands stable until its ReqReady.
//  Undefined Ctrl (4'd5, 4'd15): RespErr=1, RespData=0, RespZero=1; ALU output ignored.
//  Result width: RespData exactly WIDTH bits of BusW; no carry/overflow out.
//  Reset mid-EXEC/RESP: op discarded silently, no response; requester reissues.
//  LastGnt updates only on accept.
// CONFIGURATION
//  ALU_ARB_RR_EN defined: round-robin; on simultaneous ReqValid grant the requester != LastGnt.
//  Not defined: fixed priority, requester 0 always wins simultaneous requests; LastGnt unused.
//  Single requester active: granted immediately in either mode.
// STRUCTURE
//  Shared header alu_defs.vh: ALU op codes (AND=0 OR=1 ADD=2 SLL=3 SRL=4 SUB=6 SLT=7 ADDU=8 SUBU=9 XOR=10 SLTU=11 NOR=12 SRA=13 LUI=14).
//  Shared header also holds the FSM state encodings IDLE/EXEC/RESP.
//  One sub-module: existing ALU instance (BusW, Zero, BusA, BusB, ALUCtrl); arbiter logic inline.
// TESTING
//  Req0 ADD A=0x000000FF B=0x1 -> ReqReady0 at t, RespValid t+2, Data=0x100, Zero=0, Id=0, Err=0.
//  Req1 SUB A=1 B=1, RespReady=1 -> Data=0, Zero=1, Id=1; FSM back in IDLE next cycle.
//  Both valid continuously, RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0.
//  RespReady low 5 cycles during RESP -> Resp* held constant, ReqReady0/1 stay 0; accept after release.
//  Req0 Ctrl=5 -> RespErr=1, Data=0, Zero=1; next op SLL 0x12345678,2 -> 0x48D159E0, Err=0.
//  ResetL low during EXEC -> RespValid stays 0, outputs 0; post-reset req1 alone granted first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice: ALU op codes, arbiter
//   FSM state encoding and a helper that flags op codes with no defined
//   ALU operation.
//   No ports (package).
package alu_arbiter_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd3;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd4;
    localparam logic [OP_W-1:0] OP_UND5 = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd7;
    localparam logic [OP_W-1:0] OP_ADDU = 4'd8;
    localparam logic [OP_W-1:0] OP_SUBU = 4'd9;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd11;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd12;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd13;
    localparam logic [OP_W-1:0] OP_LUI  = 4'd14;
    localparam logic [OP_W-1:0] OP_UND15 = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arbState_e;

    function automatic logic isUndefOp(input logic [OP_W-1:0] op);
        return (op == OP_UND5) || (op == OP_UND15);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
//   Combinational ALU shared by both requesters of alu_arbiter.
//   Ports:
//     BusW    out WIDTH   result (exactly WIDTH bits, no carry/overflow)
//     Zero    out 1       BusW == 0
//     BusA    in  WIDTH   operand A
//     BusB    in  WIDTH   operand B; low log2(WIDTH) bits are the shift amount
//     ALUCtrl in  CTRL_W  op code (low 4 bits decoded)
//   Undefined op codes produce BusW = 0; the arbiter masks them anyway.
module alu_arbiter_alu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    output logic [WIDTH-1:0]  BusW,
    output logic              Zero,
    input  logic [WIDTH-1:0]  BusA,
    input  logic [WIDTH-1:0]  BusB,
    input  logic [CTRL_W-1:0] ALUCtrl
);
    import alu_arbiter_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic [OP_W-1:0]    op;

    assign shamt = BusB[SHAMT_W-1:0];
    assign op    = ALUCtrl[OP_W-1:0];

    always_comb begin
        BusW = '0;
        case (op)
            OP_AND:  BusW = BusA & BusB;
            OP_OR:   BusW = BusA | BusB;
            OP_ADD,
            OP_ADDU: BusW = BusA + BusB;
            OP_SUB,
            OP_SUBU: BusW = BusA - BusB;
            OP_SLL:  BusW = BusA << shamt;
            OP_SRL:  BusW = BusA >> shamt;
            OP_SRA:  BusW = $signed(BusA) >>> shamt;
            OP_SLT:  BusW = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
            OP_SLTU: BusW = {{(WIDTH-1){1'b0}}, (BusA < BusB)};
            OP_XOR:  BusW = BusA ^ BusB;
            OP_NOR:  BusW = ~(BusA | BusB);
            OP_LUI:  BusW = BusB << 16;
            default: BusW = '0;
        endcase
    end

    assign Zero = (BusW == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. Accepts one op at a
//   time, registers its operands, runs it through the ALU for one cycle and
//   holds the registered result on a valid/ready response channel.
//   Build option: ALU_ARB_RR_EN defined -> round-robin between simultaneous
//   requesters; undefined -> requester 0 always wins ties.
//   Ports:
//     CLK                 in  1       clock, rising edge
//     ResetL              in  1       asynchronous active-low reset
//     ReqValid0/1         in  1       requester n presents an op
//     ReqReady0/1         out 1       one-cycle accept pulse to requester n
//     ReqA0/1, ReqB0/1    in  WIDTH   operands
//     ReqCtrl0/1          in  CTRL_W  ALU op code
//     RespValid           out 1       result available
//     RespReady           in  1       consumer takes result
//     RespId              out 1       requester that issued the op
//     RespData            out WIDTH   registered ALU result
//     RespZero            out 1       registered Zero flag
//     RespErr             out 1       op code was undefined (5 or 15)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; grant + latch operands on ReqValid
//   EXEC  | ALU driven from operand regs; result captured at end of cycle
//   RESP  | RespValid high, result held until RespReady
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              CLK,
    input  logic              ResetL,
    input  logic              ReqValid0,
    input  logic              ReqValid1,
    output logic              ReqReady0,
    output logic              ReqReady1,
    input  logic [WIDTH-1:0]  ReqA0,
    input  logic [WIDTH-1:0]  ReqA1,
    input  logic [WIDTH-1:0]  ReqB0,
    input  logic [WIDTH-1:0]  ReqB1,
    input  logic [CTRL_W-1:0] ReqCtrl0,
    input  logic [CTRL_W-1:0] ReqCtrl1,
    output logic              RespValid,
    input  logic              RespReady,
    output logic              RespId,
    output logic [WIDTH-1:0]  RespData,
    output logic              RespZero,
    output logic              RespErr
);

    arbState_e state, nextState;

    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [CTRL_W-1:0] opCtrl;
    logic              opId;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              canGrant;

    logic [WIDTH-1:0]  aluBusW;
    logic              aluZero;
    logic              opUndef;

    // ResetL is folded in so ReqReady stays low while reset is held, even
    // though the FSM already sits in IDLE.
    assign canGrant = ResetL && (state == IDLE);

`ifdef ALU_ARB_RR_EN
    logic lastGnt;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (canGrant) begin
            if (ReqValid0 && ReqValid1) begin
                // Tie goes to whoever did not win last time.
                grant0 = lastGnt;
                grant1 = !lastGnt;
            end else begin
                grant0 = ReqValid0;
                grant1 = ReqValid1;
            end
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            lastGnt <= 1'b1;
        end else if (accept) begin
            lastGnt <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (canGrant) begin
            grant0 = ReqValid0;
            grant1 = ReqValid1 && !ReqValid0;
        end
    end
`endif

    assign accept = grant0 || grant1;

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ReqReady0 = 1'b0;
        ReqReady1 = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ReqReady0 = grant0;
                    ReqReady1 = grant1;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                nextState = RESP;
            end
            RESP: begin
                if (RespReady) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            opA    <= '0;
            opB    <= '0;
            opCtrl <= '0;
            opId   <= 1'b0;
        end else if (accept) begin
            opA    <= grant1 ? ReqA1    : ReqA0;
            opB    <= grant1 ? ReqB1    : ReqB0;
            opCtrl <= grant1 ? ReqCtrl1 : ReqCtrl0;
            opId   <= grant1;
        end
    end

    alu_arbiter_alu #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) uAlu (
        .BusW    (aluBusW),
        .Zero    (aluZero),
        .BusA    (opA),
        .BusB    (opB),
        .ALUCtrl (opCtrl)
    );

    assign opUndef = isUndefOp(opCtrl[OP_W-1:0]);

    // Undefined ops report a forced zero result regardless of the ALU.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            RespData <= '0;
            RespZero <= 1'b0;
            RespErr  <= 1'b0;
        end else if (state == EXEC) begin
            RespData <= opUndef ? '0 : aluBusW;
            RespZero <= opUndef ? 1'b1 : aluZero;
            RespErr  <= opUndef;
        end
    end

    assign RespValid = (state == RESP);
    assign RespId    = opId;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_SLL  = 4'd3;
    localparam logic [3:0] C_SRL  = 4'd4;
    localparam logic [3:0] C_SUB  = 4'd6;
    localparam logic [3:0] C_SLT  = 4'd7;
    localparam logic [3:0] C_ADDU = 4'd8;
    localparam logic [3:0] C_SUBU = 4'd9;
    localparam logic [3:0] C_XOR  = 4'd10;
    localparam logic [3:0] C_SLTU = 4'd11;
    localparam logic [3:0] C_NOR  = 4'd12;
    localparam logic [3:0] C_SRA  = 4'd13;

    logic              CLK = 1'b0;
    logic              ResetL = 1'b1;
    logic              ReqValid0 = 1'b0, ReqValid1 = 1'b0;
    logic              ReqReady0, ReqReady1;
    logic [WIDTH-1:0]  ReqA0 = '0, ReqA1 = '0, ReqB0 = '0, ReqB1 = '0;
    logic [CTRL_W-1:0] ReqCtrl0 = '0, ReqCtrl1 = '0;
    logic              RespValid;
    logic              RespReady = 1'b0;
    logic              RespId;
    logic [WIDTH-1:0]  RespData;
    logic              RespZero;
    logic              RespErr;

    int checkCount = 0;
    int passCount  = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .CLK       (CLK),
        .ResetL    (ResetL),
        .ReqValid0 (ReqValid0),
        .ReqValid1 (ReqValid1),
        .ReqReady0 (ReqReady0),
        .ReqReady1 (ReqReady1),
        .ReqA0     (ReqA0),
        .ReqA1     (ReqA1),
        .ReqB0     (ReqB0),
        .ReqB1     (ReqB1),
        .ReqCtrl0  (ReqCtrl0),
        .ReqCtrl1  (ReqCtrl1),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespId    (RespId),
        .RespData  (RespData),
        .RespZero  (RespZero),
        .RespErr   (RespErr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        ReqA0 = '0; ReqA1 = '0; ReqB0 = '0; ReqB1 = '0;
        ReqCtrl0 = '0; ReqCtrl1 = '0;
        RespReady = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        ResetL = 1'b0;
        tick();
        tick();
        ResetL = 1'b1;
        #1;
    endtask

    // Issues one op, waits (bounded) for accept and response, consumes it.
    // lat is the cycle count from accept to RespValid, or -1 on timeout.
    task automatic runOp(input bit who, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] data, output logic zero,
                         output logic err, output logic id, output int lat);
        int n;
        lat = -1;
        data = '0; zero = 1'b0; err = 1'b0; id = 1'b0;
        RespReady = 1'b0;
        if (who) begin
            ReqValid1 = 1'b1; ReqA1 = a; ReqB1 = b; ReqCtrl1 = ctrl;
        end else begin
            ReqValid0 = 1'b1; ReqA0 = a; ReqB0 = b; ReqCtrl0 = ctrl;
        end
        #1;
        n = 0;
        while (!(who ? ReqReady1 : ReqReady0) && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            ReqValid0 = 1'b0; ReqValid1 = 1'b0;
            return;
        end
        tick();
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        n = 1;
        while (!RespValid && n < 10) begin
            tick();
            n++;
        end
        if (RespValid) begin
            lat = n;
            data = RespData; zero = RespZero; err = RespErr; id = RespId;
            RespReady = 1'b1;
            tick();
            RespReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        clearInputs();
        #2;
        ResetL = 1'b0;
        ReqValid0 = 1'b1; ReqValid1 = 1'b1;
        #1;
        checkCount++; if (ReqReady0 !== 1'b0) $display("FAIL reset_ReqReady0: got %b want 0", ReqReady0); else passCount++;
        checkCount++; if (ReqReady1 !== 1'b0) $display("FAIL reset_ReqReady1: got %b want 0", ReqReady1); else passCount++;
        checkCount++; if (RespValid !== 1'b0) $display("FAIL reset_RespValid: got %b want 0", RespValid); else passCount++;
        checkCount++; if ({RespId, RespZero, RespErr, RespData} !== 35'h0)
            $display("FAIL reset_resp_fields: got id=%b zero=%b err=%b data=%h want all 0", RespId, RespZero, RespErr, RespData);
        else passCount++;
        tick();
        clearInputs();
        ResetL = 1'b1;
        #1;
    endtask

    task automatic test_add();
        ReqValid0 = 1'b1; ReqA0 = 32'h0000_00FF; ReqB0 = 32'h1; ReqCtrl0 = C_ADD;
        #1;
        checkCount++; if (ReqReady0 !== 1'b1) $display("FAIL add_ready_t: got %b want 1", ReqReady0); else passCount++;
        tick();
        ReqValid0 = 1'b0;
        #1;
        checkCount++; if ({RespValid, ReqReady0, ReqReady1} !== 3'b000)
            $display("FAIL add_t1_quiet: got valid=%b rdy0=%b rdy1=%b want 000", RespValid, ReqReady0, ReqReady1);
        else passCount++;
        tick();
        checkCount++; if (RespValid !== 1'b1) $display("FAIL add_valid_t2: got %b want 1", RespValid); else passCount++;
        checkCount++; if (RespData !== 32'h100) $display("FAIL add_data: got %h want 00000100", RespData); else passCount++;
        checkCount++; if ({RespZero, RespId, RespErr} !== 3'b000)
            $display("FAIL add_flags: got zero=%b id=%b err=%b want 000", RespZero, RespId, RespErr);
        else passCount++;
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        checkCount++; if (RespValid !== 1'b0) $display("FAIL add_release: got %b want 0", RespValid); else passCount++;
    endtask

    task automatic test_sub();
        RespReady = 1'b1;
        ReqValid1 = 1'b1; ReqA1 = 32'h1; ReqB1 = 32'h1; ReqCtrl1 = C_SUB;
        #1;
        checkCount++; if (ReqReady1 !== 1'b1) $display("FAIL sub_ready1: got %b want 1", ReqReady1); else passCount++;
        tick();
        ReqValid1 = 1'b0;
        tick();
        checkCount++; if ({RespValid, RespData, RespZero, RespId, RespErr} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0})
            $display("FAIL sub_resp: got valid=%b data=%h zero=%b id=%b err=%b want 1/00000000/1/1/0",
                     RespValid, RespData, RespZero, RespId, RespErr);
        else passCount++;
        tick();
        ReqValid0 = 1'b1; ReqA0 = 32'h3; ReqB0 = 32'h4; ReqCtrl0 = C_ADD;
        #1;
        checkCount++; if ({RespValid, ReqReady0} !== 2'b01)
            $display("FAIL sub_back_to_idle: got valid=%b rdy0=%b want 01", RespValid, ReqReady0);
        else passCount++;
        tick();
        ReqValid0 = 1'b0;
        tick();
        tick();
        RespReady = 1'b0;
    endtask

    task automatic test_arbitration();
        int gcnt;
        int dual;
        int gv[4];
        int gcyc[4];
        int expG[4];
`ifdef ALU_ARB_RR_EN
        expG = '{0, 1, 0, 1};
`else
        expG = '{0, 0, 0, 0};
`endif
        gcnt = 0;
        dual = 0;
        gv = '{default: -1};
        gcyc = '{default: 0};
        doReset();
        ReqValid0 = 1'b1; ReqA0 = 32'h10; ReqB0 = 32'h1; ReqCtrl0 = C_ADD;
        ReqValid1 = 1'b1; ReqA1 = 32'h20; ReqB1 = 32'h2; ReqCtrl1 = C_ADD;
        RespReady = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && gcnt < 4; cyc++) begin
            if (ReqReady0 && ReqReady1) begin
                dual++;
            end else if (ReqReady0 || ReqReady1) begin
                gv[gcnt] = ReqReady1 ? 1 : 0;
                gcyc[gcnt] = cyc;
                gcnt++;
            end
            tick();
        end
        clearInputs();
        RespReady = 1'b1;
        repeat (3) tick();
        RespReady = 1'b0;
        checkCount++; if (gcnt !== 4) $display("FAIL arb_grant_count: got %0d want 4", gcnt); else passCount++;
        checkCount++; if (dual !== 0) $display("FAIL arb_dual_grant: got %0d want 0", dual); else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (gv[i] !== expG[i]) $display("FAIL arb_grant_%0d: got %0d want %0d", i, gv[i], expG[i]);
            else passCount++;
        end
        for (int i = 0; i < 3; i++) begin
            checkCount++;
            if (gcyc[i+1] - gcyc[i] !== 3)
                $display("FAIL arb_interval_%0d: got %0d want 3", i, gcyc[i+1] - gcyc[i]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        logic [37:0] obs;
        RespReady = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 32'h0000_F0F0; ReqB0 = 32'h0000_FF00; ReqCtrl0 = C_AND;
        #1;
        checkCount++; if (ReqReady0 !== 1'b1) $display("FAIL bp_ready0: got %b want 1", ReqReady0); else passCount++;
        tick();
        ReqValid0 = 1'b0;
        tick();
        ReqValid1 = 1'b1; ReqA1 = 32'h5; ReqB1 = 32'h3; ReqCtrl1 = C_SUB;
        #1;
        for (int i = 0; i < 5; i++) begin
            obs = {RespValid, RespId, RespErr, RespZero, ReqReady0, ReqReady1, RespData};
            checkCount++;
            if (obs !== {6'b100000, 32'h0000_F000})
                $display("FAIL bp_hold_%0d: got valid=%b id=%b err=%b zero=%b rdy0=%b rdy1=%b data=%h want 1/0/0/0/0/0/0000f000",
                         i, obs[37], obs[36], obs[35], obs[34], obs[33], obs[32], obs[31:0]);
            else passCount++;
            tick();
        end
        RespReady = 1'b1;
        #1;
        checkCount++; if (ReqReady1 !== 1'b0) $display("FAIL bp_no_ready_in_resp: got %b want 0", ReqReady1); else passCount++;
        tick();
        RespReady = 1'b0;
        checkCount++; if ({RespValid, ReqReady1} !== 2'b01)
            $display("FAIL bp_accept_after_release: got valid=%b rdy1=%b want 01", RespValid, ReqReady1);
        else passCount++;
        tick();
        ReqValid1 = 1'b0;
        tick();
        checkCount++; if ({RespValid, RespId, RespData} !== {1'b1, 1'b1, 32'h2})
            $display("FAIL bp_second_resp: got valid=%b id=%b data=%h want 1/1/00000002", RespValid, RespId, RespData);
        else passCount++;
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
    endtask

    task automatic test_undef();
        logic [31:0] d;
        logic z, e, id;
        int lat;
        runOp(1'b0, 4'd5, 32'h0000_1234, 32'h1, d, z, e, id, lat);
        checkCount++; if ({lat == 2, e, z, d} !== {1'b1, 1'b1, 1'b1, 32'h0})
            $display("FAIL undef5: got lat=%0d err=%b zero=%b data=%h want 2/1/1/00000000", lat, e, z, d);
        else passCount++;
        runOp(1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, z, e, id, lat);
        checkCount++; if ({lat == 2, e, z, d, id} !== {1'b1, 1'b1, 1'b1, 32'h0, 1'b1})
            $display("FAIL undef15: got lat=%0d err=%b zero=%b data=%h id=%b want 2/1/1/00000000/1", lat, e, z, d, id);
        else passCount++;
        runOp(1'b0, C_SLL, 32'h1234_5678, 32'h2, d, z, e, id, lat);
        checkCount++; if ({lat == 2, e, z, d} !== {1'b1, 1'b0, 1'b0, 32'h48D1_59E0})
            $display("FAIL sll_after_undef: got lat=%0d err=%b zero=%b data=%h want 2/0/0/48d159e0", lat, e, z, d);
        else passCount++;
    endtask

    task automatic test_ops();
        logic [3:0]  ctl [10] = '{C_SLT, C_SLTU, C_SRA, C_SRL, C_NOR, C_XOR, C_OR, C_SUBU, C_ADDU, C_AND};
        logic [31:0] av  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0F0F_0000,
                                  32'hFF00_FF00, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
        logic [31:0] bv  [10] = '{32'h1, 32'h1, 32'h4, 32'h4, 32'h00F0_000F,
                                  32'h0FF0_0FF0, 32'h2, 32'h1, 32'h1, 32'h0F0F_0F0F};
        logic [31:0] ev  [10] = '{32'h1, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'hF000_FFF0,
                                  32'hF0F0_F0F0, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [31:0] d;
        logic z, e, id;
        int lat;
        for (int i = 0; i < 10; i++) begin
            runOp(i[0], ctl[i], av[i], bv[i], d, z, e, id, lat);
            checkCount++;
            if ({lat == 2, d, z, e, id} !== {1'b1, ev[i], ev[i] == 32'h0, 1'b0, i[0]})
                $display("FAIL op_%0d_ctrl%0d: got lat=%0d data=%h zero=%b err=%b id=%b want data=%h zero=%b id=%b",
                         i, ctl[i], lat, d, z, e, id, ev[i], ev[i] == 32'h0, i[0]);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_exec();
        RespReady = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 32'h2; ReqB0 = 32'h3; ReqCtrl0 = C_ADD;
        #1;
        checkCount++; if (ReqReady0 !== 1'b1) $display("FAIL rst_exec_ready0: got %b want 1", ReqReady0); else passCount++;
        tick();
        ReqValid0 = 1'b0;
        ResetL = 1'b0;
        ReqValid1 = 1'b1; ReqA1 = 32'h7; ReqB1 = 32'h8; ReqCtrl1 = C_ADD;
        #1;
        checkCount++; if ({RespValid, ReqReady1, RespId, RespData} !== 35'h0)
            $display("FAIL rst_exec_outputs: got valid=%b rdy1=%b id=%b data=%h want all 0", RespValid, ReqReady1, RespId, RespData);
        else passCount++;
        tick();
        checkCount++; if (RespValid !== 1'b0) $display("FAIL rst_exec_no_resp: got %b want 0", RespValid); else passCount++;
        ResetL = 1'b1;
        #1;
        checkCount++; if ({ReqReady0, ReqReady1} !== 2'b01)
            $display("FAIL rst_exec_req1_first: got rdy0=%b rdy1=%b want 01", ReqReady0, ReqReady1);
        else passCount++;
        tick();
        ReqValid1 = 1'b0;
        tick();
        checkCount++; if ({RespValid, RespId, RespData} !== {1'b1, 1'b1, 32'hF})
            $display("FAIL rst_exec_req1_resp: got valid=%b id=%b data=%h want 1/1/0000000f", RespValid, RespId, RespData);
        else passCount++;
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_undef();
        test_ops();
        test_reset_mid_exec();
        test_arbitration();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
